// File: rtl/scoreboard_hazard_unit_if.sv
// rtl/scoreboard_hazard_unit_if.sv - ID-stage issue fields and hazard/bypass results
interface scoreboard_hazard_unit_if #(
    parameter int RA_W  = 5,
    parameter int LAT_W = 2,
    parameter int SEL_W = 2
);
    logic             issue_valid;
    logic [RA_W-1:0]  issue_rs1;
    logic             issue_rs1_used;
    logic [RA_W-1:0]  issue_rs2;
    logic             issue_rs2_used;
    logic [RA_W-1:0]  issue_rd;
    logic             issue_rd_we;
    logic [LAT_W-1:0] issue_lat;
    logic             flush;
    logic             stall;
    logic             issue_fire;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_issue_cnt;

    modport master (
        output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
               issue_rd, issue_rd_we, issue_lat, flush,
        input  stall, issue_fire, fwd_a_sel, fwd_b_sel, perf_stall_cnt, perf_issue_cnt
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
               issue_rd, issue_rd_we, issue_lat, flush,
        output stall, issue_fire, fwd_a_sel, fwd_b_sel, perf_stall_cnt, perf_issue_cnt
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - per-register scoreboard driving ID stall and EX bypass selects
// Optional perf counters built only when HAZ_PERF_EN is defined.
module scoreboard_hazard_unit #(
    parameter int NREG     = 32,
    parameter int RA_W     = 5,
    parameter int WB_DEPTH = 3,
    parameter int LAT_W    = 2,
    parameter int SEL_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    scoreboard_hazard_unit_if.slave sb
);
    localparam logic [SEL_W-1:0] AGE_MAX = SEL_W'(WB_DEPTH);
    localparam logic [SEL_W-1:0] ONE     = SEL_W'(1);

    logic [NREG-1:0]  busy;
    logic [SEL_W-1:0] age [NREG];
    logic [SEL_W-1:0] lat [NREG];

    logic             rs1_live;
    logic             rs2_live;
    logic             haz_a;
    logic             haz_b;
    logic             stall_w;
    logic             fire_w;
    logic             alloc;
    logic [SEL_W-1:0] eff_lat;

    // An operand is "live" when its producer is still somewhere between EX and WB.
    always_comb begin
        rs1_live = sb.issue_rs1_used && (sb.issue_rs1 != '0) && busy[sb.issue_rs1];
        rs2_live = sb.issue_rs2_used && (sb.issue_rs2 != '0) && busy[sb.issue_rs2];
        haz_a    = rs1_live && (age[sb.issue_rs1] < lat[sb.issue_rs1]);
        haz_b    = rs2_live && (age[sb.issue_rs2] < lat[sb.issue_rs2]);
        stall_w  = sb.issue_valid && !sb.flush && (haz_a || haz_b);
        fire_w   = sb.issue_valid && !sb.flush && !stall_w && !rst;
        alloc    = fire_w && sb.issue_rd_we && (sb.issue_rd != '0);
    end

    always_comb begin
        eff_lat = ONE;
        if (int'(sb.issue_lat) == 0) begin
            eff_lat = ONE;
        end else if (int'(sb.issue_lat) > WB_DEPTH) begin
            eff_lat = AGE_MAX;
        end else begin
            eff_lat = SEL_W'(sb.issue_lat);
        end
    end

    assign sb.stall      = stall_w;
    assign sb.issue_fire = fire_w;
    assign sb.fwd_a_sel  = rs1_live ? age[sb.issue_rs1] : '0;
    assign sb.fwd_b_sel  = rs2_live ? age[sb.issue_rs2] : '0;

    // Aging runs every cycle, stalled or not; the allocate below overrides a same-cycle retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                age[r] <= '0;
                lat[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (busy[r]) begin
                    if (age[r] == AGE_MAX) begin
                        busy[r] <= 1'b0;
                        age[r]  <= '0;
                    end else begin
                        age[r] <= age[r] + ONE;
                    end
                end
            end
            if (alloc) begin
                busy[sb.issue_rd] <= 1'b1;
                age[sb.issue_rd]  <= ONE;
                lat[sb.issue_rd]  <= eff_lat;
            end
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] issue_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (stall_w && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (fire_w && (issue_cnt != '1)) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
        end
    end

    assign sb.perf_stall_cnt = stall_cnt;
    assign sb.perf_issue_cnt = issue_cnt;
`else
    assign sb.perf_stall_cnt = '0;
    assign sb.perf_issue_cnt = '0;
`endif
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb/tb_scoreboard_hazard_unit.sv - directed and randomized checks of scoreboard_hazard_unit
module tb_scoreboard_hazard_unit;
    localparam int WB = 3;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    scoreboard_hazard_unit_if #(.RA_W(5), .LAT_W(2), .SEL_W(2)) sb ();

    scoreboard_hazard_unit #(
        .NREG(32), .RA_W(5), .WB_DEPTH(WB), .LAT_W(2), .SEL_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each register remembers the cycle its latest writer issued.
    int issue_t [32];
    int lat_m   [32];
    int cyc;
    int n_stall;
    int n_issue;

    bit v_valid, v_u1, v_u2, v_we, v_flush;
    int v_rs1, v_rs2, v_rd, v_lat;

    function automatic int m_age(int r);
        int a;
        if (r == 0) return 0;
        a = cyc - issue_t[r];
        return (a >= 1 && a <= WB) ? a : 0;
    endfunction

    function automatic int m_sel(int r, bit used);
        return used ? m_age(r) : 0;
    endfunction

    function automatic bit m_haz(int r, bit used);
        return (m_sel(r, used) != 0) && (m_age(r) < lat_m[r]);
    endfunction

    function automatic bit m_stall();
        return v_valid && !v_flush && (m_haz(v_rs1, v_u1) || m_haz(v_rs2, v_u2));
    endfunction

    function automatic bit m_fire();
        return v_valid && !v_flush && !m_stall() && !rst;
    endfunction

    task automatic drive(bit valid, int rs1, bit u1, int rs2, bit u2,
                         int rd, bit we, int lat, bit fl);
        v_valid = valid; v_rs1 = rs1; v_u1 = u1; v_rs2 = rs2; v_u2 = u2;
        v_rd = rd; v_we = we; v_lat = lat; v_flush = fl;
        sb.issue_valid    = valid;
        sb.issue_rs1      = 5'(rs1);
        sb.issue_rs1_used = u1;
        sb.issue_rs2      = 5'(rs2);
        sb.issue_rs2_used = u2;
        sb.issue_rd       = 5'(rd);
        sb.issue_rd_we    = we;
        sb.issue_lat      = 2'(lat);
        sb.flush          = fl;
        #1;
    endtask

    task automatic tick();
        bit f;
        bit s;
        f = m_fire();
        s = m_stall();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                issue_t[r] = -1000;
                lat_m[r]   = 1;
            end
            n_stall = 0;
            n_issue = 0;
        end else begin
            if (f && v_we && v_rd != 0) begin
                issue_t[v_rd] = cyc;
                lat_m[v_rd]   = (v_lat == 0) ? 1 : ((v_lat > WB) ? WB : v_lat);
            end
            n_stall += int'(s);
            n_issue += int'(f);
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 3, 1, 4, 1, 6, 1, 1, 0);
        total++; if (sb.issue_fire !== 1'b0) $display("FAIL reset_fire got %0d want 0", sb.issue_fire); else passed++;
        tick();
        total++; if (sb.stall !== 1'b0) $display("FAIL reset_stall got %0d want 0", sb.stall); else passed++;
        total++; if (sb.fwd_a_sel !== 2'd0) $display("FAIL reset_fwd_a got %0d want 0", sb.fwd_a_sel); else passed++;
        total++; if (sb.fwd_b_sel !== 2'd0) $display("FAIL reset_fwd_b got %0d want 0", sb.fwd_b_sel); else passed++;
        total++; if (sb.issue_fire !== 1'b0) $display("FAIL reset_fire2 got %0d want 0", sb.issue_fire); else passed++;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_alu_forward();
        logic [1:0] want [4];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        total++; if (sb.issue_fire !== 1'b1) $display("FAIL alu_issue got %0d want 1", sb.issue_fire); else passed++;
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 5, 1, 0, 0, 0, 0, 1, 0);
            total++; if (sb.stall !== 1'b0) $display("FAIL alu_stall_age%0d got %0d want 0", k + 1, sb.stall); else passed++;
            total++; if (sb.fwd_a_sel !== want[k]) $display("FAIL alu_fwd_a_age%0d got %0d want %0d", k + 1, sb.fwd_a_sel, want[k]); else passed++;
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 2, 0);
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 1, 0);
        total++; if (sb.stall !== 1'b1) $display("FAIL load_use_stall got %0d want 1", sb.stall); else passed++;
        total++; if (sb.issue_fire !== 1'b0) $display("FAIL load_use_fire0 got %0d want 0", sb.issue_fire); else passed++;
        tick();
        total++; if (sb.stall !== 1'b0) $display("FAIL load_use_release got %0d want 0", sb.stall); else passed++;
        total++; if (sb.issue_fire !== 1'b1) $display("FAIL load_use_fire1 got %0d want 1", sb.issue_fire); else passed++;
        total++; if (sb.fwd_b_sel !== 2'd2) $display("FAIL load_use_fwd_b got %0d want 2", sb.fwd_b_sel); else passed++;
        tick();
`ifdef HAZ_PERF_EN
        total++; if (sb.perf_stall_cnt !== 32'd1) $display("FAIL perf_stall got %0d want 1", sb.perf_stall_cnt); else passed++;
        total++; if (sb.perf_issue_cnt !== 32'd2) $display("FAIL perf_issue got %0d want 2", sb.perf_issue_cnt); else passed++;
`else
        total++; if (sb.perf_stall_cnt !== 32'd0) $display("FAIL perf_stall got %0d want 0", sb.perf_stall_cnt); else passed++;
        total++; if (sb.perf_issue_cnt !== 32'd0) $display("FAIL perf_issue got %0d want 0", sb.perf_issue_cnt); else passed++;
`endif
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 2, 0);
        tick();
        drive(1, 0, 0, 7, 1, 9, 1, 1, 1);
        total++; if (sb.stall !== 1'b0) $display("FAIL flush_stall got %0d want 0", sb.stall); else passed++;
        total++; if (sb.issue_fire !== 1'b0) $display("FAIL flush_fire got %0d want 0", sb.issue_fire); else passed++;
        tick();
        drive(1, 9, 1, 7, 1, 0, 0, 1, 0);
        total++; if (sb.fwd_a_sel !== 2'd0) $display("FAIL flush_no_alloc got %0d want 0", sb.fwd_a_sel); else passed++;
        total++; if (sb.fwd_b_sel !== 2'd2) $display("FAIL flush_inflight_age2 got %0d want 2", sb.fwd_b_sel); else passed++;
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 1, 0);
        total++; if (sb.fwd_b_sel !== 2'd3) $display("FAIL flush_inflight_age3 got %0d want 3", sb.fwd_b_sel); else passed++;
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 1, 0);
        total++; if (sb.fwd_b_sel !== 2'd0) $display("FAIL flush_retired got %0d want 0", sb.fwd_b_sel); else passed++;
        tick();
    endtask

    task automatic test_x0_waw();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 2, 0);
        tick();
        drive(1, 0, 1, 0, 0, 0, 0, 1, 0);
        total++; if (sb.stall !== 1'b0) $display("FAIL x0_stall got %0d want 0", sb.stall); else passed++;
        total++; if (sb.fwd_a_sel !== 2'd0) $display("FAIL x0_fwd_a got %0d want 0", sb.fwd_a_sel); else passed++;
        tick();
        drive(1, 0, 0, 0, 0, 4, 1, 2, 0);
        tick();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0);
        total++; if (sb.issue_fire !== 1'b1) $display("FAIL waw_fire got %0d want 1", sb.issue_fire); else passed++;
        tick();
        drive(1, 4, 1, 0, 0, 0, 0, 1, 0);
        total++; if (sb.stall !== 1'b0) $display("FAIL waw_stall got %0d want 0", sb.stall); else passed++;
        total++; if (sb.fwd_a_sel !== 2'd1) $display("FAIL waw_fwd_a got %0d want 1", sb.fwd_a_sel); else passed++;
        tick();
    endtask

    task automatic test_clamp_reset();
        do_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0);
        tick();
        drive(1, 6, 1, 0, 0, 0, 0, 1, 0);
        total++; if (sb.stall !== 1'b0) $display("FAIL clamp_stall got %0d want 0", sb.stall); else passed++;
        total++; if (sb.fwd_a_sel !== 2'd1) $display("FAIL clamp_fwd_a got %0d want 1", sb.fwd_a_sel); else passed++;
        tick();
        for (int r = 1; r <= 3; r++) begin
            drive(1, 0, 0, 0, 0, r, 1, 2, 0);
            tick();
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 3, 1, 2, 1, 0, 0, 1, 0);
        total++; if (sb.stall !== 1'b0) $display("FAIL midreset_stall got %0d want 0", sb.stall); else passed++;
        total++; if (sb.fwd_a_sel !== 2'd0) $display("FAIL midreset_fwd_a got %0d want 0", sb.fwd_a_sel); else passed++;
        total++; if (sb.fwd_b_sel !== 2'd0) $display("FAIL midreset_fwd_b got %0d want 0", sb.fwd_b_sel); else passed++;
        tick();
    endtask

    task automatic test_random();
        int es;
        int ef;
        int ea;
        int eb;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            es = int'(m_stall());
            ef = int'(m_fire());
            ea = m_sel(v_rs1, v_u1);
            eb = m_sel(v_rs2, v_u2);
            total++; if (int'(sb.stall) !== es) $display("FAIL rnd_stall cyc %0d got %0d want %0d", cyc, sb.stall, es); else passed++;
            total++; if (int'(sb.issue_fire) !== ef) $display("FAIL rnd_fire cyc %0d got %0d want %0d", cyc, sb.issue_fire, ef); else passed++;
            if (es == 0) begin
                total++; if (int'(sb.fwd_a_sel) !== ea) $display("FAIL rnd_fwd_a cyc %0d got %0d want %0d", cyc, sb.fwd_a_sel, ea); else passed++;
                total++; if (int'(sb.fwd_b_sel) !== eb) $display("FAIL rnd_fwd_b cyc %0d got %0d want %0d", cyc, sb.fwd_b_sel, eb); else passed++;
            end
            tick();
        end
        rst = 1'b0;
`ifdef HAZ_PERF_EN
        total++; if (int'(sb.perf_stall_cnt) !== n_stall) $display("FAIL rnd_perf_stall got %0d want %0d", sb.perf_stall_cnt, n_stall); else passed++;
        total++; if (int'(sb.perf_issue_cnt) !== n_issue) $display("FAIL rnd_perf_issue got %0d want %0d", sb.perf_issue_cnt, n_issue); else passed++;
`else
        total++; if (sb.perf_stall_cnt !== 32'd0) $display("FAIL rnd_perf_stall got %0d want 0", sb.perf_stall_cnt); else passed++;
        total++; if (sb.perf_issue_cnt !== 32'd0) $display("FAIL rnd_perf_issue got %0d want 0", sb.perf_issue_cnt); else passed++;
`endif
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        cyc     = 0;
        n_stall = 0;
        n_issue = 0;
        for (int r = 0; r < 32; r++) begin
            issue_t[r] = -1000;
            lat_m[r]   = 1;
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_forward();
        test_load_use();
        test_flush();
        test_x0_waw();
        test_clamp_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the fixed load-use/forwarding hazard logic of the 5-stage core.
- Tracks every in-flight register writer in a per-register scoreboard (busy, age, latency), so any result latency up to WB_DEPTH is supported (multi-cycle loads, a future multiplier).
- Produces the ID-stage stall, the issue strobe and per-operand bypass-tap selects.
- Sits beside id_stage. Consumes decoded operand/destination fields and drives the IF/ID hold and the EX operand muxes.

Parameters:
- NREG, 32: architectural register count; register 0 is hardwired zero.
- RA_W, 5: register address width; must satisfy 2**RA_W >= NREG.
- WB_DEPTH, 3: stages from EX to WB inclusive; an entry stays busy for ages 1..WB_DEPTH.
- LAT_W, 2: width of the latency field.
- SEL_W, 2: bypass-select width; must hold the value WB_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  ID holds a valid decoded instruction.
- issue_rs1  in  RA_W  source 1 index.
- issue_rs1_used  in  1  source 1 is read.
- issue_rs2  in  RA_W  source 2 index.
- issue_rs2_used  in  1  source 2 is read.
- issue_rd  in  RA_W  destination index.
- issue_rd_we  in  1  instruction writes rd.
- issue_lat  in  LAT_W  age at which the result becomes forwardable (ALU=1, load=2).
- flush  in  1  branch taken in EX; kill the instruction in ID.
- stall  out  1  hold PC and IF/ID; inject a bubble into ID/EX.
- issue_fire  out  1  the instruction leaves ID this cycle.
- fwd_a_sel  out  SEL_W  source 1 bypass tap; 0 = register file, k = tap at age k.
- fwd_b_sel  out  SEL_W  source 2 bypass tap, same encoding.
- perf_stall_cnt  out  32  stall-cycle count (see Optional Feature).
- perf_issue_cnt  out  32  issued-instruction count (see Optional Feature).

Behaviour:
- State per register r: busy[r], age[r] (0..WB_DEPTH), lat[r] (1..WB_DEPTH).
- Register 0 is never busy.
- Reset (rst=1 at a clk edge): all busy, age and lat cleared; perf counters cleared. Outputs are combinational from state, so after reset stall=0 and fwd selects=0. While rst=1, issue_fire=0.
- Latency normalisation: effective latency = max(1, min(issue_lat, WB_DEPTH)).
- Operand hazard for source x (x = rs1 or rs2): raised when x_used & x!=0 & busy[x] & age[x] < lat[x].
- stall = issue_valid & !flush & (hazard on rs1 | hazard on rs2). stall is combinational with zero latency.
- issue_fire = issue_valid & !flush & !stall & !rst.
- fwd_a_sel: equals age[rs1] when rs1_used & rs1!=0 & busy[rs1]; otherwise 0. fwd_b_sel follows the same rule for rs2. Selects are valid whenever no hazard is raised.
- Aging, every non-reset edge: for each busy entry, age increments. When age==WB_DEPTH, busy clears and age returns to 0. WB taps are forwarded; the register file is not write-through.
- Allocate: on issue_fire & issue_rd_we & issue_rd!=0, set busy[rd]=1, age[rd]=1, lat[rd]=effective latency.
- Simultaneous allocate and retire of the same rd: allocate wins.
- WAW: a younger writer overwrites the entry. This is safe because writeback is in order at fixed depth.
- Stalled cycles still age the scoreboard, so a hazard resolves by itself; no state machine beyond the counters.
- flush overrides a hazard: stall=0, issue_fire=0 and no allocate. In-flight entries (older instructions) are unaffected.

Optional Feature:
- Macro HAZ_PERF_EN.
- When defined: perf_stall_cnt increments on each cycle with stall=1, and perf_issue_cnt increments on each cycle with issue_fire=1. Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst.
- When undefined: no counter flops are built and both outputs are tied to 0.

Test Plan:
- Reset then idle: rst held 2 cycles -> stall=0, fwd_a_sel=fwd_b_sel=0, issue_fire=0 during reset.
- ALU dependency: issue rd=5 lat=1, next cycle rs1=5 -> no stall, fwd_a_sel=1; one cycle later rs1=5 -> fwd_a_sel=2; at age 3 -> 3; at age 4 -> 0.
- Load-use: issue rd=7 lat=2, next cycle rs2=7 -> stall=1 for exactly 1 cycle, then issue_fire=1 with fwd_b_sel=2; with HAZ_PERF_EN, perf_stall_cnt=1 and perf_issue_cnt=2.
- Flush: load rd=7 lat=2 in flight, dependent in ID with flush=1 -> stall=0, issue_fire=0, no allocate; entry 7 still retires after age 3.
- x0 and WAW: issue rd=0 lat=2, then rs1=0 -> no stall, fwd_a_sel=0. Then issue rd=4 lat=2, next cycle rd=4 lat=1 (this cycle stalls only if it reads x4); after the younger writer issues, a reader of x4 sees fwd_a_sel=1.
- Latency clamp and mid-op reset: issue_lat=0 behaves as 1. Assert rst with 3 entries busy -> next cycle every select=0 and stall=0.
